// File: rtl/hidden_forward.sv
// -----------------------------------------------------------------------------
// hidden_forward
//
// Forward pass for one hidden neuron and its output synapse. This module
// produces the activation and network output that the backprop weight-update
// block later reads back as hidden_val_i / final_i.
//
// The neuron sums four binary-gated 8-bit weights plus a bias, one term per
// cycle. ReLU, a left shift and saturation to 10 bits give the hidden
// activation. That activation is then multiplied by the output weight.
//
// Ports
//   clk_i               in   1   clock, rising edge
//   rst_i               in   1   synchronous active-high reset
//   start_i             in   1   begin a pass (accepted only while idle)
//   zero_weight_reset_i in   1   synchronous clear, same effect as rst_i
//   x_i                 in   4   binary inputs, bit k gates weight k
//   w0_i..w3_i          in   8   hidden weights, two's complement
//   bias_i              in   8   hidden bias, two's complement
//   out_w_i             in   8   output weight, two's complement
//   busy_o              out  1   high whenever a pass is in flight
//   valid_o             out  1   one-cycle pulse, results below are fresh
//   hidden_val_o        out  10  unsigned hidden activation
//   final_o             out  19  two's complement network output
//
// Timing: start is accepted on edge N. busy_o is high in cycles N+1..N+7,
// and valid_o is high in cycle N+7. The results are registered on the same
// edge that raises valid_o, so they can be read during the pulse. The results
// then hold until the next completed pass.
// -----------------------------------------------------------------------------
module hidden_forward #(
    parameter int HID_SHIFT = 1,
    parameter int N_IN      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        zero_weight_reset_i,
    input  logic [3:0]  x_i,
    input  logic [7:0]  w0_i,
    input  logic [7:0]  w1_i,
    input  logic [7:0]  w2_i,
    input  logic [7:0]  w3_i,
    input  logic [7:0]  bias_i,
    input  logic [7:0]  out_w_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [9:0]  hidden_val_o,
    output logic [18:0] final_o
);

    localparam int DATA_W  = 10;   // hidden activation width
    localparam int COEF_W  = 8;    // weight / bias width
    localparam int ACC_W   = 11;   // covers -640..635 without overflow
    localparam int PROD_W  = 18;   // 11-bit unsigned-in-signed x 8-bit signed
    localparam int FIN_W   = 19;
    localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [31:0] HID_MAX = (32'd1 << DATA_W) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_ACT   = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // Either clear source returns the engine to idle with zeroed results.
    logic clr;
    assign clr = rst_i | zero_weight_reset_i;

    // Operands captured at the accept edge, so the inputs may change
    // while the pass runs.
    logic        [N_IN-1:0]   x_q;
    logic signed [COEF_W-1:0] w_q [N_IN];
    logic signed [COEF_W-1:0] out_w_q;

    logic        [IDX_W-1:0]  idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic        [DATA_W-1:0] hidden_q;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------
    function automatic logic signed [ACC_W-1:0] sext_acc(
        input logic signed [COEF_W-1:0] v
    );
        return {{(ACC_W-COEF_W){v[COEF_W-1]}}, v};
    endfunction

    // ReLU, then shift, then clamp to the unsigned activation range.
    function automatic logic [DATA_W-1:0] relu_sat(
        input logic signed [ACC_W-1:0] a
    );
        logic [31:0] h;
        if (a < 0) begin
            return '0;
        end
        h = {{(32-ACC_W){1'b0}}, a} << HID_SHIFT;
        if (h > HID_MAX) begin
            return HID_MAX[DATA_W-1:0];
        end
        return h[DATA_W-1:0];
    endfunction

    // The activation is treated as a non-negative signed value. The product
    // fits in 18 bits and is then sign-extended to the output width.
    function automatic logic signed [FIN_W-1:0] mul_out(
        input logic        [DATA_W-1:0] h,
        input logic signed [COEF_W-1:0] w
    );
        logic signed [PROD_W-1:0] he;
        logic signed [PROD_W-1:0] we;
        logic signed [PROD_W-1:0] p;
        he = {{(PROD_W-DATA_W){1'b0}}, h};
        we = {{(PROD_W-COEF_W){w[COEF_W-1]}}, w};
        p  = he * we;
        return {p[PROD_W-1], p};
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_ACCUM;
            S_ACCUM: if (idx_q == IDX_W'(N_IN - 1)) state_d = S_ACT;
            S_ACT:   state_d = S_MUL;
            S_MUL:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o  = (state_q != S_IDLE);
        valid_o = (state_q == S_DONE);
    end

    // -------------------------------------------------------------------------
    // Operand capture (data only, not cleared)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && start_i) begin
            x_q     <= x_i;
            w_q[0]  <= w0_i;
            w_q[1]  <= w1_i;
            w_q[2]  <= w2_i;
            w_q[3]  <= w3_i;
            out_w_q <= out_w_i;
        end
    end

    // -------------------------------------------------------------------------
    // Accumulate / activate / multiply datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (clr) begin
            acc_q        <= '0;
            idx_q        <= '0;
            hidden_q     <= '0;
            hidden_val_o <= '0;
            final_o      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        // The bias seeds the sum, so x_i == 0 still yields ReLU(bias).
                        acc_q <= sext_acc(bias_i);
                        idx_q <= '0;
                    end
                end
                S_ACCUM: begin
                    if (x_q[idx_q]) begin
                        acc_q <= acc_q + sext_acc(w_q[idx_q]);
                    end
                    idx_q <= idx_q + IDX_W'(1);
                end
                S_ACT: begin
                    hidden_q <= relu_sat(acc_q);
                end
                S_MUL: begin
                    // Publish on entry to DONE so data and valid_o coincide.
                    hidden_val_o <= hidden_q;
                    final_o      <= mul_out(hidden_q, out_w_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_forward.sv
module tb_hidden_forward;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        zero_weight_reset_i;
    logic [3:0]  x_i;
    logic [7:0]  w0_i, w1_i, w2_i, w3_i, bias_i, out_w_i;
    logic        busy_o;
    logic        valid_o;
    logic [9:0]  hidden_val_o;
    logic [18:0] final_o;

    always #5 clk_i = ~clk_i;

    hidden_forward #(.HID_SHIFT(1), .N_IN(4)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start_i             (start_i),
        .zero_weight_reset_i (zero_weight_reset_i),
        .x_i                 (x_i),
        .w0_i                (w0_i),
        .w1_i                (w1_i),
        .w2_i                (w2_i),
        .w3_i                (w3_i),
        .bias_i              (bias_i),
        .out_w_i             (out_w_i),
        .busy_o              (busy_o),
        .valid_o             (valid_o),
        .hidden_val_o        (hidden_val_o),
        .final_o             (final_o)
    );

    typedef struct {
        logic [3:0]  x;
        logic [7:0]  w0, w1, w2, w3, bias, ow;
        logic [9:0]  eh;
        logic [18:0] ef;
    } vec_t;

    vec_t vt[8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        x_i = v.x; w0_i = v.w0; w1_i = v.w1; w2_i = v.w2; w3_i = v.w3;
        bias_i = v.bias; out_w_i = v.ow;
    endtask

    // Scramble the inputs after acceptance. Results must come from the captured values.
    task automatic scramble();
        x_i = 4'b1010; w0_i = 8'h55; w1_i = 8'hAA; w2_i = 8'h33;
        w3_i = 8'hCC; bias_i = 8'h7F; out_w_i = 8'h80;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Accept a start on the next edge. Sample 1 is the cycle right after
    // acceptance, and valid_o is expected at sample 7.
    task automatic do_pass(input vec_t v, input string tag);
        int lat;
        int busy_n;
        @(negedge clk_i);
        set_inputs(v);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        scramble();
        lat = -1;
        busy_n = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy_o) busy_n++;
            if (valid_o) begin
                lat = c;
                break;
            end
            tick();
        end
        chk({tag, "_latency"}, lat, 7);
        chk({tag, "_busy_cycles"}, busy_n, 7);
        chk({tag, "_hidden"}, {22'd0, hidden_val_o}, {22'd0, v.eh});
        chk({tag, "_final"}, {13'd0, final_o}, {13'd0, v.ef});
        tick();
        chk({tag, "_valid_drop"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int nvalid;
        int gap;
        int first;

        //        x        w0     w1     w2     w3     bias   ow     hid     final
        vt[0] = '{4'b1111, 8'd10, 8'd20, 8'd30, 8'd40, 8'd0,  8'd3,  10'd200, 19'd600};
        vt[1] = '{4'b0101, 8'd5,  8'd99, 8'hFD, 8'd99, 8'd1,  8'hFF, 10'd6,   19'h7FFFA};
        vt[2] = '{4'b1111, 8'h80, 8'h80, 8'h80, 8'h80, 8'd0,  8'd5,  10'd0,   19'd0};
        vt[3] = '{4'b1111, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 10'd1023, 19'h60080};
        vt[4] = '{4'b0000, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'd50, 8'd2,  10'd100, 19'd200};
        vt[5] = '{4'b0000, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFB, 8'd9,  10'd0,   19'd0};
        vt[6] = '{4'b1000, 8'h7F, 8'h7F, 8'h7F, 8'hF9, 8'd20, 8'h7F, 10'd26,  19'd3302};
        vt[7] = '{4'b0110, 8'd0,  8'h7F, 8'h7F, 8'd0,  8'd0,  8'hFF, 10'd508, 19'h7FE04};

        rst_i = 1'b1; start_i = 1'b0; zero_weight_reset_i = 1'b0;
        set_inputs(vt[0]);
        tick(); tick();
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_hidden", {22'd0, hidden_val_o}, 32'd0);
        chk("rst_final", {13'd0, final_o}, 32'd0);

        // Reset overrides a simultaneous start.
        start_i = 1'b1;
        tick();
        chk("rst_over_start", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table-driven passes
        for (int i = 0; i < 8; i++) begin
            do_pass(vt[i], $sformatf("vec%0d", i));
        end

        // Results hold while idle
        tick(); tick(); tick();
        chk("hold_hidden", {22'd0, hidden_val_o}, 32'd508);
        chk("hold_final", {13'd0, final_o}, {13'd0, 19'h7FE04});

        // Start held high: start in DONE is ignored, so pulses are 8 cycles apart.
        @(negedge clk_i);
        set_inputs(vt[0]);
        start_i = 1'b1;
        first = -1;
        gap = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid_o) begin
                if (first < 0) first = c;
                else if (gap < 0) gap = c - first;
            end
        end
        start_i = 1'b0;
        chk("b2b_gap", gap, 8);
        chk("b2b_hidden", {22'd0, hidden_val_o}, 32'd200);
        for (int c = 0; c < 10; c++) tick();

        // A start pulse while busy is ignored: only one valid_o pulse.
        @(negedge clk_i);
        set_inputs(vt[1]);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        nvalid = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) start_i = 1'b1;
            if (c == 4) start_i = 1'b0;
            if (valid_o) nvalid++;
            tick();
        end
        chk("repulse_valid_count", nvalid, 1);
        chk("repulse_final", {13'd0, final_o}, {13'd0, 19'h7FFFA});

        // rst_i mid-pass aborts the pass and zeroes the results.
        @(negedge clk_i);
        set_inputs(vt[3]);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_hidden", {22'd0, hidden_val_o}, 32'd0);
        chk("abort_final", {13'd0, final_o}, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            if (valid_o) nvalid++;
            tick();
        end
        chk("abort_no_valid", nvalid, 0);

        // zero_weight_reset_i mid-pass behaves the same way.
        do_pass(vt[0], "pre_zwr");
        @(negedge clk_i);
        set_inputs(vt[3]);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick();
        zero_weight_reset_i = 1'b1;
        tick();
        zero_weight_reset_i = 1'b0;
        chk("zwr_busy", {31'd0, busy_o}, 32'd0);
        chk("zwr_hidden", {22'd0, hidden_val_o}, 32'd0);
        chk("zwr_final", {13'd0, final_o}, 32'd0);
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            if (valid_o) nvalid++;
            tick();
        end
        chk("zwr_no_valid", nvalid, 0);

        // The engine still works after a clear.
        do_pass(vt[6], "post_zwr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
